// File: rtl/regfile_pkg.sv
// Shared Y86 register-file definitions: data widths, register IDs and the
// debug-port state encoding.
package regfile_pkg;

  localparam int WORD   = 32;
  localparam int NIBBLE = 4;

  localparam logic [NIBBLE-1:0] REAX  = 4'h0;
  localparam logic [NIBBLE-1:0] RECX  = 4'h1;
  localparam logic [NIBBLE-1:0] REDX  = 4'h2;
  localparam logic [NIBBLE-1:0] REBX  = 4'h3;
  localparam logic [NIBBLE-1:0] RESP  = 4'h4;
  localparam logic [NIBBLE-1:0] REBP  = 4'h5;
  localparam logic [NIBBLE-1:0] RESI  = 4'h6;
  localparam logic [NIBBLE-1:0] REDI  = 4'h7;
  localparam logic [NIBBLE-1:0] RNONE = 4'hF;

  typedef enum logic {
    DBG_IDLE = 1'b0,
    DBG_RESP = 1'b1
  } dbg_state_e;

  // IDs 8..15 (illegal IDs and RNONE) all have the top bit set.
  function automatic logic is_reg(input logic [NIBBLE-1:0] id);
    return (id[NIBBLE-1] == 1'b0);
  endfunction

endpackage

// File: rtl/regfile_dbg.sv
// Debug read port: samples the selected register on a request and presents
// it for one cycle; a request arriving during the response cycle waits.
module regfile_dbg
  import regfile_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            i_req,
  input  logic [WORD-1:0] i_rdata,
  output logic [WORD-1:0] o_data,
  output dbg_state_e      o_state
);

  dbg_state_e      r_state;
  dbg_state_e      w_next;
  logic            w_capture;
  logic [WORD-1:0] r_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= DBG_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      DBG_IDLE: if (i_req) w_next = DBG_RESP;
      DBG_RESP: w_next = DBG_IDLE;
      default:  w_next = DBG_IDLE;
    endcase
  end

  always_comb begin
    w_capture = (r_state == DBG_IDLE) && i_req;
  end

  // i_rdata is the pre-write register value at the capturing edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            r_data <= '0;
    else if (w_capture) r_data <= i_rdata;
  end

  assign o_data  = r_data;
  assign o_state = r_state;

endmodule

// File: rtl/regfile.sv
// Y86 architectural register file: two combinational decode read ports, two
// write-back write ports (M wins on a shared destination), retired-write
// counter and a registered debug read port.
module regfile
  import regfile_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [NIBBLE-1:0] d_srcA_i,
  input  logic [NIBBLE-1:0] d_srcB_i,
  output logic [WORD-1:0]   d_rvalA_o,
  output logic [WORD-1:0]   d_rvalB_o,
  input  logic              W_en_i,
  input  logic [NIBBLE-1:0] W_dstE_i,
  input  logic [WORD-1:0]   W_valE_i,
  input  logic [NIBBLE-1:0] W_dstM_i,
  input  logic [WORD-1:0]   W_valM_i,
  input  logic [2:0]        dbg_addr_i,
  input  logic              dbg_req_i,
  output logic [WORD-1:0]   dbg_data_o,
  output logic              dbg_valid_o,
  output logic [31:0]       wr_count_o
);

  logic [WORD-1:0] r_regs [8];
  logic [31:0]     r_wr_count;
  logic            w_we_e;
  logic            w_we_m;
  logic [1:0]      w_inc;
  logic [WORD-1:0] w_dbg_rdata;
  dbg_state_e      w_dbg_state;

  // popl %esp: both ports target the same register, M carries the value.
  assign w_we_m = W_en_i && is_reg(W_dstM_i);
  assign w_we_e = W_en_i && is_reg(W_dstE_i) && (W_dstE_i != W_dstM_i);
  assign w_inc  = {1'b0, w_we_e} + {1'b0, w_we_m};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) r_regs[i] <= '0;
      r_wr_count <= '0;
    end else begin
      if (w_we_e) r_regs[W_dstE_i[2:0]] <= W_valE_i;
      if (w_we_m) r_regs[W_dstM_i[2:0]] <= W_valM_i;
      r_wr_count <= r_wr_count + {30'd0, w_inc};
    end
  end

  always_comb begin
    d_rvalA_o = '0;
    d_rvalB_o = '0;
    if (is_reg(d_srcA_i)) d_rvalA_o = r_regs[d_srcA_i[2:0]];
    if (is_reg(d_srcB_i)) d_rvalB_o = r_regs[d_srcB_i[2:0]];
  end

  assign w_dbg_rdata = r_regs[dbg_addr_i];

  regfile_dbg u_dbg (
    .clk     (clk),
    .rst     (rst),
    .i_req   (dbg_req_i),
    .i_rdata (w_dbg_rdata),
    .o_data  (dbg_data_o),
    .o_state (w_dbg_state)
  );

  assign dbg_valid_o = (w_dbg_state == DBG_RESP);
  assign wr_count_o  = r_wr_count;

endmodule
